// File: rtl/icache_refill_unit_if.sv
// Word-wide instruction memory read bus.
// master: refill unit, slave: memory.
interface icache_refill_unit_if #(
  parameter int ADDR_W = 32
);
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output rd,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  rd,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/icache_refill_unit.sv
// I-cache line refill: fetches a full line beat by beat,
// forwards the missed word early and stalls fetch meanwhile.
module icache_refill_unit #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           miss_req,
  input  logic [ADDR_W-1:0]              miss_addr,
  icache_refill_unit_if.master           mem,
  output logic                           line_valid,
  output logic [ADDR_W-1:0]              line_addr,
  output logic [WORDS_PER_LINE*32-1:0]   line_data,
  output logic                           fwd_valid,
  output logic [31:0]                    fwd_word,
  output logic                           stall
);
  localparam int BW = $clog2(WORDS_PER_LINE);
  localparam int LW = WORDS_PER_LINE * 32;
  localparam logic [BW-1:0] LAST = BW'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] OFS_MASK =
    ADDR_W'(WORDS_PER_LINE * 4 - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     crit;
  logic [ADDR_W-1:0] base;
  logic [LW-1:0]     buf_q;
  logic [LW-1:0]     merged;
  logic              fetch;

  assign fetch = (state == FETCH);

  // Partial line with the arriving beat already folded in;
  // on the last beat this is the complete line.
  always_comb begin
    merged = buf_q;
    merged[32*beat +: 32] = mem.rdata;
  end

  // Memory request and status outputs decoded from state.
  always_comb begin
    mem.rd     = fetch;
    mem.addr   = '0;
    if (fetch)
      mem.addr = base + ADDR_W'({beat, 2'b00});
    stall      = (state != IDLE);
    line_valid = (state == DONE);
  end

  // Refill sequencer: latch miss, collect beats, publish line.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= '0;
      crit      <= '0;
      base      <= '0;
      buf_q     <= '0;
      line_data <= '0;
      line_addr <= '0;
      fwd_valid <= 1'b0;
      fwd_word  <= '0;
    end else begin
      fwd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (miss_req) begin
            base  <= miss_addr & ~OFS_MASK;
            crit  <= miss_addr[BW+1:2];
            beat  <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (mem.ack) begin
            buf_q <= merged;
            if (beat == crit) begin
              fwd_valid <= 1'b1;
              fwd_word  <= mem.rdata;
            end
            if (beat == LAST) begin
              line_data <= merged;
              line_addr <= base;
              state     <= DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_refill_unit.sv
// Randomized scoreboard bench for icache_refill_unit.
// Expected beats/forwards/lines come from a memory image model.
module tb_icache_refill_unit;
  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
  } line_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         line_valid;
  logic [31:0]  line_addr;
  logic [127:0] line_data;
  logic         fwd_valid;
  logic [31:0]  fwd_word;
  logic         stall;

  icache_refill_unit_if #(.ADDR_W(32)) mif ();

  icache_refill_unit #(
    .WORDS_PER_LINE(4),
    .ADDR_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .miss_req(miss_req),
    .miss_addr(miss_addr),
    .mem(mif),
    .line_valid(line_valid),
    .line_addr(line_addr),
    .line_data(line_data),
    .fwd_valid(fwd_valid),
    .fwd_word(fwd_word),
    .stall(stall)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model: word image, programmable wait states, spurious ack.
  logic [31:0] img [0:1023];
  int  wcnt = 0;
  int  wait_cfg = 0;
  logic spur = 1'b0;

  always @(posedge clock) begin
    if (mif.rd && !mif.ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always_comb begin
    mif.ack   = (mif.rd && (wcnt >= wait_cfg)) || spur;
    mif.rdata = spur ? 32'h0000_DEAD : img[mif.addr[11:2]];
  end

  // Scoreboard queues.
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_fwd_q  [$];
  line_t       exp_line_q [$];
  logic [127:0] last_line = '0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got strobe expected none", name);
  endtask

  // Reference: a refill of address a reads the aligned 16-byte
  // block in ascending word order and forwards the word at a.
  task automatic expect_refill(input logic [31:0] a);
    logic [31:0] b;
    line_t l;
    b = a & ~32'hF;
    l.addr = b;
    l.data = '0;
    for (int k = 0; k < 4; k++) begin
      exp_addr_q.push_back(b + 32'(4 * k));
      l.data[32*k +: 32] = img[10'((b >> 2) + 32'(k))];
    end
    exp_fwd_q.push_back(img[a[11:2]]);
    exp_line_q.push_back(l);
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clock) begin
    if (mon_en) begin
      if (mif.rd) begin
        if (exp_addr_q.size() == 0) flag("mem_rd_unexpected");
        else begin
          chk("mem_addr", mif.addr, exp_addr_q[0]);
          if (mif.ack) void'(exp_addr_q.pop_front());
        end
      end
      if (fwd_valid) begin
        if (exp_fwd_q.size() == 0) flag("fwd_valid_unexpected");
        else chk("fwd_word", fwd_word, exp_fwd_q.pop_front());
      end
      if (line_valid) begin
        if (exp_line_q.size() == 0) flag("line_valid_unexpected");
        else begin
          line_t l;
          l = exp_line_q.pop_front();
          chk("line_addr", line_addr, l.addr);
          chk("line_data", line_data, l.data);
          last_line = l.data;
        end
      end
    end
  end

  task automatic issue_miss(input logic [31:0] a, output int n);
    @(posedge clock); #1;
    miss_req  = 1'b1;
    miss_addr = a;
    n = cyc;
    @(posedge clock); #1;
    miss_req = 1'b0;
  endtask

  task automatic wait_line(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (line_valid) begin
        at = cyc;
        return;
      end
    end
    flag("line_valid_timeout");
  endtask

  task automatic wait_fwd(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (fwd_valid) begin
        at = cyc;
        return;
      end
    end
    flag("fwd_valid_timeout");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, at, lo, lv, acks;
    logic [31:0] ra;
    for (int i = 0; i < 1024; i++) img[i] = $urandom;
    img[16] = 32'h11;
    img[17] = 32'h22;
    img[18] = 32'h33;
    img[19] = 32'h44;

    reset = 1'b1;
    miss_req = 1'b0;
    miss_addr = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_stall", stall, 0);
    chk("rst_mem_rd", mif.rd, 0);
    chk("rst_mem_addr", mif.addr, 0);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_line_addr", line_addr, 0);
    chk("rst_line_data", line_data, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_fwd_word", fwd_word, 0);
    mon_en = 1'b1;

    // Zero-wait refill of 0x48.
    expect_refill(32'h48);
    issue_miss(32'h48, n);
    wait_fwd(at);
    chk("zw_fwd_word", fwd_word, 32'h33);
    wait_line(at);
    chk("zw_latency", 32'(at - n), 5);
    chk("zw_line_addr", line_addr, 32'h40);
    chk("zw_line_data", line_data,
        128'h00000044_00000033_00000022_00000011);

    // Spurious ack while idle.
    @(posedge clock); #1 spur = 1'b1;
    @(posedge clock); #1 spur = 1'b0;
    @(negedge clock);
    chk("spur_line_data", line_data,
        128'h00000044_00000033_00000022_00000011);
    chk("spur_stall", stall, 0);
    repeat (3) @(negedge clock);

    // Critical word at line start.
    expect_refill(32'h30);
    issue_miss(32'h30, n);
    wait_fwd(at);
    chk("crit0_fwd_time", 32'(at - n), 2);
    wait_line(at);

    // Three wait states per beat.
    wait_cfg = 3;
    expect_refill(32'h64);
    issue_miss(32'h64, n);
    lo = 0;
    lv = -1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clock);
      if (cyc <= n + 17 && !stall) lo++;
      if (line_valid) lv = cyc;
    end
    chk("ws_stall_gaps", 32'(lo), 0);
    chk("ws_latency", 32'(lv - n), 17);
    chk("ws_stall_after", stall, 0);
    wait_cfg = 0;

    // Back-to-back: held miss, address changed during FETCH.
    expect_refill(32'h100);
    expect_refill(32'h20C);
    @(posedge clock); #1;
    miss_req  = 1'b1;
    miss_addr = 32'h100;
    repeat (2) @(posedge clock);
    #1 miss_addr = 32'h20C;
    wait_line(at);
    @(posedge clock); #1;
    @(negedge clock);
    chk("b2b_idle_gap", stall, 0);
    @(posedge clock); #1 miss_req = 1'b0;
    @(negedge clock);
    chk("b2b_second_stall", stall, 1);
    chk("b2b_second_addr", mif.addr, 32'h200);
    wait_line(at);

    // Reset mid-refill after the second ack.
    expect_refill(32'h80);
    issue_miss(32'h80, n);
    acks = 0;
    for (int i = 0; i < 50 && acks < 2; i++) begin
      if (i > 0) @(negedge clock);
      else @(negedge clock);
      if (mif.rd && mif.ack) acks++;
    end
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    exp_addr_q.delete();
    exp_fwd_q.delete();
    exp_line_q.delete();
    reset = 1'b0;
    @(negedge clock);
    chk("rr_stall", stall, 0);
    chk("rr_mem_rd", mif.rd, 0);
    chk("rr_line_data", line_data, 0);
    repeat (4) @(negedge clock);
    expect_refill(32'h80);
    issue_miss(32'h80, n);
    @(negedge clock);
    chk("rr_restart_addr", mif.addr, 32'h80);
    wait_line(at);

    // Reset together with miss_req: miss is dropped.
    @(posedge clock); #1;
    reset = 1'b1;
    miss_req = 1'b1;
    miss_addr = 32'h500;
    @(posedge clock); #1;
    reset = 1'b0;
    miss_req = 1'b0;
    @(negedge clock);
    chk("rm_stall", stall, 0);
    chk("rm_mem_rd", mif.rd, 0);

    // Random refills with random wait states.
    for (int t = 0; t < 24; t++) begin
      ra = 32'($urandom_range(0, 1023)) << 2;
      wait_cfg = int'($urandom_range(0, 3));
      expect_refill(ra);
      issue_miss(ra, n);
      wait_line(at);
      chk("rnd_latency", 32'(at - n), 32'(5 + 4 * wait_cfg));
    end
    wait_cfg = 0;
    repeat (3) @(negedge clock);

    chk("end_addr_q", 32'(exp_addr_q.size()), 0);
    chk("end_fwd_q", 32'(exp_fwd_q.size()), 0);
    chk("end_line_q", 32'(exp_line_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
